bus_sequencer: RTL



---
 rtl/bus_seq_pkg.sv | 16 +
 rtl/bus_sequencer_strobe_decode.sv | 19 +
 rtl/bus_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_seq_pkg.sv
// Shared state encoding and opcode constants for the register-file strobe sequencer.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  localparam logic OP_MOVE = 1'b0;
  localparam logic OP_ALU  = 1'b1;

  localparam int SEQ_LEN = 4;

endpackage

// File: rtl/bus_sequencer_strobe_decode.sv
// Index-plus-enable to active-low one-hot strobe vector; out-of-range indices select nothing.
module strobe_decode #(
  parameter int NREGS = 4,
  parameter int IDXW  = 3
) (
  input  logic [IDXW-1:0]  idx,
  input  logic             en,
  output logic [NREGS-1:0] strobe_bar
);

  // One-hot low decode, every bit high when disabled
  always_comb begin
    strobe_bar = {NREGS{1'b1}};
    for (int i = 0; i < NREGS; i++) begin
      strobe_bar[i] = !(en && (idx == i[IDXW-1:0]));
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Sequences BUS/LHS/RHS/LOAD strobes for one register transfer at a time.
// Strobes are decoded from next-state and re-timed through flops so the register file never sees decode glitches.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int IDXW  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_OP,
  input  logic [IDXW-1:0]  REQ_SRC_A,
  input  logic [IDXW-1:0]  REQ_SRC_B,
  input  logic [IDXW-1:0]  REQ_DST,
  output logic [NREGS-1:0] ASSERT_bar,
  output logic [NREGS-1:0] ASSERT_LHS_bar,
  output logic [NREGS-1:0] ASSERT_RHS_bar,
  output logic [NREGS-1:0] LOAD_bar,
  output logic             ALU_OE_bar,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [IDXW:0] NREGS_W = NREGS[IDXW:0];

  seq_state_t      state_r, state_nx_s;
  logic            op_r, op_nx_s;
  logic [IDXW-1:0] a_r, a_nx_s, b_r, b_nx_s, dst_r, dst_nx_s;
  logic            bad_r, bad_nx_s;
  logic            accept_s, active_s, bus_en_s, alu_en_s, load_en_s;
  logic [NREGS-1:0] bus_dec_s, lhs_dec_s, rhs_dec_s, load_dec_s;

  function automatic logic idx_bad(input logic [IDXW-1:0] idx);
    return ({1'b0, idx} >= NREGS_W);
  endfunction

  // Next request fields, next state and strobe-group enables for the coming cycle
  always_comb begin
    accept_s = REQ_VALID && REQ_READY;
    if (accept_s) begin
      op_nx_s  = REQ_OP;
      a_nx_s   = REQ_SRC_A;
      b_nx_s   = REQ_SRC_B;
      dst_nx_s = REQ_DST;
      // RHS index only matters for ALU requests
      bad_nx_s = idx_bad(REQ_SRC_A) || idx_bad(REQ_DST) ||
                 ((REQ_OP == OP_ALU) && idx_bad(REQ_SRC_B));
    end else begin
      op_nx_s  = op_r;
      a_nx_s   = a_r;
      b_nx_s   = b_r;
      dst_nx_s = dst_r;
      bad_nx_s = bad_r;
    end

    case (state_r)
      ST_IDLE:  state_nx_s = accept_s ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_nx_s = ST_LATCH;
      ST_LATCH: state_nx_s = ST_HOLD;
      ST_HOLD:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase

    active_s  = (state_nx_s != ST_IDLE) && !bad_nx_s;
    bus_en_s  = active_s && (op_nx_s == OP_MOVE) && (a_nx_s != dst_nx_s);
    alu_en_s  = active_s && (op_nx_s == OP_ALU);
    load_en_s = (state_nx_s == ST_LATCH) && (bus_en_s || alu_en_s);
  end

  strobe_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_bus_dec (
    .idx(a_nx_s), .en(bus_en_s), .strobe_bar(bus_dec_s)
  );
  strobe_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_lhs_dec (
    .idx(a_nx_s), .en(alu_en_s), .strobe_bar(lhs_dec_s)
  );
  strobe_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_rhs_dec (
    .idx(b_nx_s), .en(alu_en_s), .strobe_bar(rhs_dec_s)
  );
  strobe_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_load_dec (
    .idx(dst_nx_s), .en(load_en_s), .strobe_bar(load_dec_s)
  );

  // Sequencer state, captured request and registered strobe outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r        <= ST_IDLE;
      op_r           <= OP_MOVE;
      a_r            <= {IDXW{1'b0}};
      b_r            <= {IDXW{1'b0}};
      dst_r          <= {IDXW{1'b0}};
      bad_r          <= 1'b0;
      REQ_READY      <= 1'b1;
      ASSERT_bar     <= {NREGS{1'b1}};
      ASSERT_LHS_bar <= {NREGS{1'b1}};
      ASSERT_RHS_bar <= {NREGS{1'b1}};
      LOAD_bar       <= {NREGS{1'b1}};
      ALU_OE_bar     <= 1'b1;
      DONE           <= 1'b0;
      ERR            <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      op_r           <= op_nx_s;
      a_r            <= a_nx_s;
      b_r            <= b_nx_s;
      dst_r          <= dst_nx_s;
      bad_r          <= bad_nx_s;
      REQ_READY      <= (state_nx_s == ST_IDLE);
      ASSERT_bar     <= bus_dec_s;
      ASSERT_LHS_bar <= lhs_dec_s;
      ASSERT_RHS_bar <= rhs_dec_s;
      LOAD_bar       <= load_dec_s;
      ALU_OE_bar     <= !alu_en_s;
      DONE           <= (state_nx_s == ST_HOLD);
      ERR            <= (state_nx_s == ST_HOLD) && bad_nx_s;
    end
  end

endmodule
